// File: rtl/prog_mem_pkg.sv
// Shared opcode/operand constants and clear-FSM state type for the banked program memory.
package prog_mem_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_MOV  = 8'h07;
    localparam logic [7:0] OP_HALT = 8'h32;

    localparam logic [7:0] OPND_REG    = 8'h00;
    localparam logic [7:0] OPND_INPUT  = 8'h01;
    localparam logic [7:0] OPND_OUTPUT = 8'h02;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

endpackage

// File: rtl/prog_mem_bank.sv
// One program bank: single write port and a registered FETCH_W-word read whose address wraps.
module prog_mem_bank #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int FETCH_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [FETCH_W*DATA_W-1:0]   rdata
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            for (int i = 0; i < FETCH_W; i++) begin
                rdata[i*DATA_W +: DATA_W] <= mem[raddr + ADDR_W'(i)];
            end
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Banked program memory: operator load port with edge-detected send, HALT-fill clear sweep,
// and a CPU fetch port returning FETCH_W consecutive words.
//
// state     | meaning
// CLR_IDLE  | no sweep; writes and fetches allowed
// CLR_SWEEP | writing FILL_WORD to sweep_addr of sweep_bank each cycle; busy=1
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                BANKS     = 4,
    parameter int                FETCH_W   = 4,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(OP_HALT),
    localparam int               BANK_W    = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        edit,
    input  logic                        send,
    input  logic                        auto_inc,
    input  logic [ADDR_W-1:0]           unit,
    input  logic [DATA_W-1:0]           code,
    input  logic [BANK_W-1:0]           bank_wr,
    input  logic [BANK_W-1:0]           bank_rd,
    input  logic                        fetch_req,
    input  logic [ADDR_W-1:0]           fetch_addr,
    output logic [FETCH_W*DATA_W-1:0]   fetch_data,
    output logic                        fetch_valid,
    output logic                        wr_ack,
    output logic [ADDR_W-1:0]           wr_ptr,
    output logic                        busy,
    output logic                        drop
);
    clr_state_e state, state_nxt;

    logic              send_q, clr_q, edit_q;
    logic              send_edge, clr_edge, edit_edge;
    logic              clr_start, wr_go, fetch_go;
    logic [ADDR_W-1:0] wr_addr, sweep_addr, mem_addr;
    logic [BANK_W-1:0] sweep_bank, rd_bank_q;
    logic [DATA_W-1:0] mem_data;

    logic [FETCH_W*DATA_W-1:0] bank_rdata [BANKS];

    assign send_edge = send & ~send_q;
    assign clr_edge  = clr & ~clr_q;
    assign edit_edge = edit & ~edit_q;

    // A clear starting this cycle outranks a coincident send.
    assign clr_start = clr_edge && (state == CLR_IDLE);
    assign wr_go     = send_edge & edit & ~busy & ~clr_start;
    assign fetch_go  = fetch_req & ~edit & ~busy;
    assign wr_addr   = auto_inc ? wr_ptr : unit;
    assign mem_addr  = busy ? sweep_addr : wr_addr;
    assign mem_data  = busy ? FILL_WORD : code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLR_IDLE:  if (clr_edge) state_nxt = CLR_SWEEP;
            CLR_SWEEP: if (sweep_addr == '1) state_nxt = CLR_IDLE;
            default:   state_nxt = CLR_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CLR_SWEEP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sweep_addr <= '0;
            sweep_bank <= '0;
        end else if (clr_start) begin
            sweep_addr <= '0;
            sweep_bank <= bank_wr;
        end else if (busy) begin
            sweep_addr <= sweep_addr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            send_q      <= 1'b0;
            clr_q       <= 1'b0;
            edit_q      <= 1'b0;
            wr_ack      <= 1'b0;
            wr_ptr      <= '0;
            drop        <= 1'b0;
            fetch_valid <= 1'b0;
            rd_bank_q   <= '0;
        end else begin
            send_q      <= send;
            clr_q       <= clr;
            edit_q      <= edit;
            wr_ack      <= wr_go;
            fetch_valid <= fetch_go;
            if (fetch_go) begin
                rd_bank_q <= bank_rd;
            end
            if (edit_edge) begin
                wr_ptr <= '0;
            end else if (wr_go && auto_inc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (send_edge && !wr_go) begin
                drop <= 1'b1;
            end else if (edit_edge) begin
                drop <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic bank_we;
        // Memory writes are suppressed while rst is asserted so a reset mid-sweep stops cleanly.
        assign bank_we = ~rst & ((wr_go & (bank_wr == BANK_W'(b))) |
                                 (busy & (sweep_bank == BANK_W'(b))));

        prog_mem_bank #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .FETCH_W (FETCH_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we),
            .waddr (mem_addr),
            .wdata (mem_data),
            .rd_en (fetch_go && (bank_rd == BANK_W'(b))),
            .raddr (fetch_addr),
            .rdata (bank_rdata[b])
        );
    end

    assign fetch_data = bank_rdata[rd_bank_q];

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader against an array-based model of the program banks.
module tb_prog_mem_loader;

    localparam int DEPTH = 256;
    localparam int NB    = 4;

    logic        clk = 1'b0;
    logic        rst, clr, edit, send, auto_inc, fetch_req;
    logic [7:0]  unit, code, fetch_addr;
    logic [1:0]  bank_wr, bank_rd;
    logic [31:0] fetch_data;
    logic        fetch_valid, wr_ack, busy, drop;
    logic [7:0]  wr_ptr;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [NB][DEPTH];
    logic [7:0] ptr_m;

    always #5 clk = ~clk;

    prog_mem_loader #(
        .DATA_W(8), .ADDR_W(8), .BANKS(4), .FETCH_W(4), .FILL_WORD(8'h32)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .edit(edit), .send(send), .auto_inc(auto_inc),
        .unit(unit), .code(code), .bank_wr(bank_wr), .bank_rd(bank_rd),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
        .fetch_valid(fetch_valid), .wr_ack(wr_ack), .wr_ptr(wr_ptr), .busy(busy), .drop(drop)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_fetch(input int b, input int a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = model[b][(a + i) % DEPTH];
        return r;
    endfunction

    function automatic void mwrite(input int b, input logic ai, input logic [7:0] u, input logic [7:0] c);
        if (ai) begin
            model[b][ptr_m] = c;
            ptr_m = ptr_m + 8'd1;
        end else begin
            model[b][u] = c;
        end
    endfunction

    task automatic set_edit(input logic v);
        if (v && edit !== 1'b1) ptr_m = 8'd0;
        edit = v;
        tick;
    endtask

    task automatic send_word(input logic ai, input logic [7:0] u, input logic [7:0] c,
                             output logic ack0, output logic ack1);
        auto_inc = ai; unit = u; code = c; send = 1'b1;
        tick;
        ack0 = wr_ack;
        send = 1'b0;
        tick;
        ack1 = wr_ack;
    endtask

    task automatic do_fetch(input logic [1:0] b, input logic [7:0] a,
                            output logic [31:0] d, output logic v0, output logic v1);
        bank_rd = b; fetch_addr = a; fetch_req = 1'b1;
        tick;
        v0 = fetch_valid;
        d  = fetch_data;
        fetch_req = 1'b0;
        tick;
        v1 = fetch_valid;
    endtask

    task automatic clear_bank(input logic [1:0] b, output int cnt);
        bank_wr = b; clr = 1'b1;
        tick;
        clr = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 300) begin
            cnt++;
            tick;
        end
        for (int a = 0; a < DEPTH; a++) model[b][a] = 8'h32;
    endtask

    task automatic test_reset;
        checks++; if (fetch_data !== 32'h0) begin failures++; $display("FAIL reset_fetch_data got=%h exp=0", fetch_data); end
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid got=%b exp=0", fetch_valid); end
        checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL reset_wr_ack got=%b exp=0", wr_ack); end
        checks++; if (wr_ptr !== 8'h0) begin failures++; $display("FAIL reset_wr_ptr got=%h exp=0", wr_ptr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (drop !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop); end
    endtask

    task automatic test_init_clear;
        int cnt;
        for (int b = 0; b < NB; b++) begin
            clear_bank(2'(b), cnt);
            checks++; if (cnt != 256) begin failures++; $display("FAIL init_busy_len bank=%0d got=%0d exp=256", b, cnt); end
        end
    endtask

    task automatic test_explicit_write;
        logic a0, a1, v0, v1;
        logic [31:0] d;
        set_edit(1'b1);
        bank_wr = 2'd0;
        send_word(1'b0, 8'd0, 8'h00, a0, a1); mwrite(0, 1'b0, 8'd0, 8'h00);
        checks++; if (a0 !== 1'b1 || a1 !== 1'b0) begin failures++; $display("FAIL t1_ack0 got=%b%b exp=10", a0, a1); end
        send_word(1'b0, 8'd1, 8'h07, a0, a1); mwrite(0, 1'b0, 8'd1, 8'h07);
        checks++; if (a0 !== 1'b1 || a1 !== 1'b0) begin failures++; $display("FAIL t1_ack1 got=%b%b exp=10", a0, a1); end
        set_edit(1'b0);
        do_fetch(2'd0, 8'd0, d, v0, v1);
        checks++; if (d[15:0] !== 16'h0700) begin failures++; $display("FAIL t1_fetch got=%h exp=0700", d[15:0]); end
        checks++; if (v0 !== 1'b1 || v1 !== 1'b0) begin failures++; $display("FAIL t1_valid got=%b%b exp=10", v0, v1); end
    endtask

    task automatic test_auto_inc;
        logic a0, a1, v0, v1;
        logic [31:0] d;
        logic [7:0] seq [4];
        seq[0] = 8'h01; seq[1] = 8'h00; seq[2] = 8'h07; seq[3] = 8'h01;
        set_edit(1'b1);
        bank_wr = 2'd0;
        for (int i = 0; i < 4; i++) begin
            send_word(1'b1, 8'hFF, seq[i], a0, a1);
            mwrite(0, 1'b1, 8'hFF, seq[i]);
        end
        checks++; if (wr_ptr !== 8'd4) begin failures++; $display("FAIL t2_wr_ptr got=%0d exp=4", wr_ptr); end
        set_edit(1'b0);
        do_fetch(2'd0, 8'd0, d, v0, v1);
        checks++; if (d !== 32'h01070001) begin failures++; $display("FAIL t2_fetch got=%h exp=01070001", d); end
    endtask

    task automatic test_wrap;
        logic a0, a1, v0, v1;
        logic [31:0] d;
        logic [7:0] c;
        int acks = 0;
        set_edit(1'b1);
        bank_wr = 2'd0;
        for (int i = 0; i < 255; i++) begin
            c = 8'($urandom);
            send_word(1'b1, 8'($urandom), c, a0, a1);
            mwrite(0, 1'b1, 8'h00, c);
            if (a0 === 1'b1) acks++;
        end
        checks++; if (acks != 255) begin failures++; $display("FAIL t3_acks got=%0d exp=255", acks); end
        checks++; if (wr_ptr !== 8'd255) begin failures++; $display("FAIL t3_ptr_pre got=%0d exp=255", wr_ptr); end
        send_word(1'b1, 8'h00, 8'hAA, a0, a1); mwrite(0, 1'b1, 8'h00, 8'hAA);
        checks++; if (wr_ptr !== 8'd0) begin failures++; $display("FAIL t3_ptr_wrap got=%0d exp=0", wr_ptr); end
        set_edit(1'b0);
        do_fetch(2'd0, 8'd254, d, v0, v1);
        checks++; if (d !== exp_fetch(0, 254) || d[15:8] !== 8'hAA) begin
            failures++; $display("FAIL t3_fetch_wrap got=%h exp=%h", d, exp_fetch(0, 254));
        end
    endtask

    task automatic test_clear;
        logic a0, a1, v0, v1;
        logic [31:0] d;
        logic [7:0] u, c;
        int cnt, n;
        set_edit(1'b1);
        bank_wr = 2'd1;
        for (int i = 0; i < 8; i++) begin
            u = 8'($urandom); c = 8'($urandom_range(0, 8'h31));
            send_word(1'b0, u, c, a0, a1); mwrite(1, 1'b0, u, c);
        end
        clear_bank(2'd1, cnt);
        checks++; if (cnt != 256) begin failures++; $display("FAIL t4_busy_len got=%0d exp=256", cnt); end
        bank_wr = 2'd2; clr = 1'b1;
        tick;
        clr = 1'b0;
        repeat (3) tick;
        send_word(1'b0, 8'd5, 8'h5A, a0, a1);
        checks++; if (a0 !== 1'b0 || a1 !== 1'b0) begin failures++; $display("FAIL t4_busy_ack got=%b%b exp=00", a0, a1); end
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL t4_drop got=%b exp=1", drop); end
        n = 0;
        while (busy === 1'b1 && n < 300) begin n++; tick; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t4_sweep_timeout busy=%b exp=0", busy); end
        for (int a = 0; a < DEPTH; a++) model[2][a] = 8'h32;
        set_edit(1'b0);
        for (int a = 0; a < DEPTH; a += 4) begin
            do_fetch(2'd1, 8'(a), d, v0, v1);
            checks++; if (d !== exp_fetch(1, a)) begin failures++; $display("FAIL t4_bank1 addr=%0d got=%h exp=%h", a, d, exp_fetch(1, a)); end
        end
        for (int i = 0; i < 8; i++) begin
            u = 8'($urandom);
            do_fetch(2'd0, u, d, v0, v1);
            checks++; if (d !== exp_fetch(0, u)) begin failures++; $display("FAIL t4_bank0 addr=%0d got=%h exp=%h", u, d, exp_fetch(0, u)); end
        end
        checks++; if (drop !== 1'b1) begin failures++; $display("FAIL t4_drop_sticky got=%b exp=1", drop); end
        set_edit(1'b1);
        checks++; if (drop !== 1'b0 || wr_ptr !== 8'd0) begin failures++; $display("FAIL t4_edit_clear drop=%b ptr=%0d exp=0/0", drop, wr_ptr); end
    endtask

    task automatic test_collision_and_rst;
        logic a0, a1, v0, v1;
        logic [31:0] d;
        logic [7:0] c;
        logic [7:0] pts [5];
        pts[0] = 8'd92; pts[1] = 8'd96; pts[2] = 8'd98; pts[3] = 8'd100; pts[4] = 8'd108;
        bank_wr = 2'd3;
        for (int a = 90; a < 115; a++) begin
            c = 8'($urandom_range(0, 8'h31));
            send_word(1'b0, 8'(a), c, a0, a1); mwrite(3, 1'b0, 8'(a), c);
        end
        auto_inc = 1'b0; unit = 8'd0; code = 8'hC3;
        clr = 1'b1; send = 1'b1;
        tick;
        checks++; if (wr_ack !== 1'b0 || drop !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL t5_collide ack=%b drop=%b busy=%b exp=0/1/1", wr_ack, drop, busy);
        end
        clr = 1'b0; send = 1'b0;
        repeat (100) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ptr_m = 8'd0;
        for (int a = 0; a < 100; a++) model[3][a] = 8'h32;
        checks++; if (busy !== 1'b0 || drop !== 1'b0) begin failures++; $display("FAIL t5_rst busy=%b drop=%b exp=0/0", busy, drop); end
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t5_rst_idle busy=%b exp=0", busy); end
        set_edit(1'b0);
        for (int i = 0; i < 5; i++) begin
            do_fetch(2'd3, pts[i], d, v0, v1);
            checks++; if (d !== exp_fetch(3, pts[i])) begin failures++; $display("FAIL t5_partial addr=%0d got=%h exp=%h", pts[i], d, exp_fetch(3, pts[i])); end
        end
    endtask

    task automatic test_hold_and_gating;
        logic v0, v1;
        logic [31:0] d, held;
        logic [7:0] c;
        int acks = 0, n = 0;
        set_edit(1'b1);
        bank_wr = 2'd0; auto_inc = 1'b1; c = 8'($urandom); code = c; send = 1'b1;
        repeat (10) begin tick; if (wr_ack === 1'b1) acks++; end
        send = 1'b0;
        tick; if (wr_ack === 1'b1) acks++;
        mwrite(0, 1'b1, 8'h00, c);
        checks++; if (acks != 1) begin failures++; $display("FAIL t6_hold_acks got=%0d exp=1", acks); end
        checks++; if (wr_ptr !== ptr_m) begin failures++; $display("FAIL t6_hold_ptr got=%0d exp=%0d", wr_ptr, ptr_m); end
        held = fetch_data;
        bank_rd = 2'd0; fetch_addr = 8'd0; fetch_req = 1'b1;
        tick;
        fetch_req = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || fetch_data !== held) begin
            failures++; $display("FAIL t6_fetch_edit valid=%b data=%h exp=0/%h", fetch_valid, fetch_data, held);
        end
        set_edit(1'b0);
        bank_wr = 2'd2; clr = 1'b1;
        tick;
        clr = 1'b0; fetch_req = 1'b1;
        tick;
        fetch_req = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin failures++; $display("FAIL t6_fetch_busy valid=%b exp=0", fetch_valid); end
        while (busy === 1'b1 && n < 300) begin n++; tick; end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        ptr_m = 8'd0;
        checks++; if (fetch_data !== 32'h0 || wr_ptr !== 8'd0) begin failures++; $display("FAIL t6_rst data=%h ptr=%0d exp=0/0", fetch_data, wr_ptr); end
        do_fetch(2'd0, 8'd0, d, v0, v1);
        checks++; if (d !== exp_fetch(0, 0) || v0 !== 1'b1) begin failures++; $display("FAIL t6_rst_keep got=%h exp=%h", d, exp_fetch(0, 0)); end
    endtask

    task automatic test_random;
        logic a0, a1, v0, v1;
        logic [31:0] d;
        logic [7:0] u, c;
        logic [1:0] b;
        int op;
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 2));
            b = 2'($urandom); u = 8'($urandom); c = 8'($urandom);
            if (op < 2) begin
                if (edit !== 1'b1) set_edit(1'b1);
                bank_wr = b;
                send_word(op == 1, u, c, a0, a1);
                mwrite(b, op == 1, u, c);
                checks++; if (a0 !== 1'b1 || a1 !== 1'b0 || wr_ptr !== ptr_m) begin
                    failures++; $display("FAIL rnd_write it=%0d ack=%b%b ptr=%0d exp=10/%0d", it, a0, a1, wr_ptr, ptr_m);
                end
            end else begin
                if (edit !== 1'b0) set_edit(1'b0);
                do_fetch(b, u, d, v0, v1);
                checks++; if (d !== exp_fetch(b, u) || v0 !== 1'b1 || v1 !== 1'b0) begin
                    failures++; $display("FAIL rnd_fetch it=%0d bank=%0d addr=%0d got=%h exp=%h", it, b, u, d, exp_fetch(b, u));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; edit = 1'b0; send = 1'b0; auto_inc = 1'b0; fetch_req = 1'b0;
        unit = 8'h0; code = 8'h0; fetch_addr = 8'h0; bank_wr = 2'd0; bank_rd = 2'd0;
        ptr_m = 8'd0;
        tick;
        tick;
        rst = 1'b0;
        test_reset();
        test_init_clear();
        test_explicit_write();
        test_auto_inc();
        test_wrap();
        test_clear();
        test_collision_and_rst();
        test_hold_and_gating();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
